// File: rtl/wb_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Package     : wb_pkg                                                  |
// | Description : Shared types and load-size encodings for the MEM/WB     |
// |               writeback stage.                                        |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
package wb_pkg;

  // Writeback result source; the reserved code behaves like the ALU path.
  typedef enum logic [1:0] {
    RES_ALU  = 2'b00,
    RES_MEM  = 2'b01,
    RES_PC4  = 2'b10,
    RES_RSVD = 2'b11
  } result_src_t;

  // RV32I load funct3 encodings.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

endpackage
`default_nettype wire

// File: rtl/writeback_stage_load_align.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : load_align                                              |
// | Description : Extracts the addressed byte/halfword from an aligned    |
// |               memory word, sign/zero extends it, and reports whether  |
// |               the access size is misaligned for the byte offset.      |
// |               Formatting assumes a 32-bit data word.                  |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module load_align
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] word,
  input  logic [1:0]            off,
  input  logic [2:0]            funct3,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  misaligned
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Lane select: byte by full offset, halfword by offset bit 1.
  always_comb begin
    w_byte = word[7:0];
    case (off)
      2'd0:    w_byte = word[7:0];
      2'd1:    w_byte = word[15:8];
      2'd2:    w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
    w_half = off[1] ? word[31:16] : word[15:0];
  end

  // Extension by load type; unlisted funct3 codes are treated as a full word.
  always_comb begin
    data       = word;
    misaligned = 1'b0;
    case (funct3)
      F3_LB:   data = {{(DATA_WIDTH-8){w_byte[7]}}, w_byte};
      F3_LBU:  data = {{(DATA_WIDTH-8){1'b0}}, w_byte};
      F3_LH: begin
        data       = {{(DATA_WIDTH-16){w_half[15]}}, w_half};
        misaligned = off[0];
      end
      F3_LHU: begin
        data       = {{(DATA_WIDTH-16){1'b0}}, w_half};
        misaligned = off[0];
      end
      default: begin
        data       = word;
        misaligned = (off != 2'b00);
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/writeback_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : writeback_stage                                         |
// | Description : MEM/WB pipeline register, load formatting, result       |
// |               select, retired-instruction counter and sticky          |
// |               misaligned-load flag.                                   |
// |               Optional macro WB_FORWARD_EN adds fwd_valid/fwd_rd/     |
// |               fwd_data copies of the write port for EX forwarding.    |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module writeback_stage
  import wb_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 5,
  parameter int CNT_WIDTH     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic                     in_reg_write,
  input  logic [ADDRESS_WIDTH-1:0] in_rd,
  input  logic [1:0]               in_result_src,
  input  logic [2:0]               in_funct3,
  input  logic [DATA_WIDTH-1:0]    in_alu_result,
  input  logic [DATA_WIDTH-1:0]    in_mem_rdata,
  input  logic [DATA_WIDTH-1:0]    in_pc_plus4,
  output logic                     write_en,
  output logic [ADDRESS_WIDTH-1:0] write_addr,
  output logic [DATA_WIDTH-1:0]    write_data,
  output logic [CNT_WIDTH-1:0]     retired,
  output logic                     misalign_err
`ifdef WB_FORWARD_EN
  ,
  output logic                     fwd_valid,
  output logic [ADDRESS_WIDTH-1:0] fwd_rd,
  output logic [DATA_WIDTH-1:0]    fwd_data
`endif
);

  logic                     r_valid;
  logic                     r_reg_write;
  logic [ADDRESS_WIDTH-1:0] r_rd;
  result_src_t              r_src;
  logic [2:0]               r_funct3;
  logic [DATA_WIDTH-1:0]    r_alu;
  logic [DATA_WIDTH-1:0]    r_rdata;
  logic [DATA_WIDTH-1:0]    r_pc4;
  logic [CNT_WIDTH-1:0]     r_retired;
  logic                     r_misalign;

  logic [DATA_WIDTH-1:0]    w_load_data;
  logic                     w_size_mis;
  logic                     w_mis;

  // Pipeline capture; flush turns the captured slot into a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_rd        <= '0;
      r_src       <= RES_ALU;
      r_funct3    <= 3'b000;
      r_alu       <= '0;
      r_rdata     <= '0;
      r_pc4       <= '0;
    end else begin
      r_valid     <= in_valid & ~flush;
      r_reg_write <= in_reg_write;
      r_rd        <= in_rd;
      r_src       <= result_src_t'(in_result_src);
      r_funct3    <= in_funct3;
      r_alu       <= in_alu_result;
      r_rdata     <= in_mem_rdata;
      r_pc4       <= in_pc_plus4;
    end
  end

  load_align #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_load_align (
    .word       (r_rdata),
    .off        (r_alu[1:0]),
    .funct3     (r_funct3),
    .data       (w_load_data),
    .misaligned (w_size_mis)
  );

  // Only a valid load can be misaligned; other sources ignore the offset.
  assign w_mis = r_valid & (r_src == RES_MEM) & w_size_mis;

  // Result select; the reserved source falls back to the ALU result.
  always_comb begin
    write_data = r_alu;
    case (r_src)
      RES_MEM: write_data = w_load_data;
      RES_PC4: write_data = r_pc4;
      default: write_data = r_alu;
    endcase
  end

  assign write_en   = r_valid & r_reg_write & (r_rd != '0) & ~w_mis;
  assign write_addr = r_rd;

  // Retire counter (wraps) and sticky misalign flag, both cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_retired  <= '0;
      r_misalign <= 1'b0;
    end else begin
      if (r_valid) begin
        r_retired <= r_retired + CNT_WIDTH'(1);
      end
      if (w_mis) begin
        r_misalign <= 1'b1;
      end
    end
  end

  assign retired      = r_retired;
  assign misalign_err = r_misalign;

`ifdef WB_FORWARD_EN
  assign fwd_valid = write_en;
  assign fwd_rd    = write_addr;
  assign fwd_data  = write_data;
`endif

endmodule
`default_nettype wire

// File: tb/tb_writeback_stage.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module      : tb_writeback_stage                                      |
// | Description : Self-checking bench for writeback_stage: a behavioural  |
// |               reference model checked every negedge, plus directed    |
// |               literal expectations.                                   |
// | Revision    : 1.0 - initial release                                   |
// +-----------------------------------------------------------------------+
module tb_writeback_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_reg_write;
  logic [4:0]  in_rd;
  logic [1:0]  in_result_src;
  logic [2:0]  in_funct3;
  logic [31:0] in_alu_result;
  logic [31:0] in_mem_rdata;
  logic [31:0] in_pc_plus4;
  logic        write_en;
  logic [4:0]  write_addr;
  logic [31:0] write_data;
  logic [63:0] retired;
  logic        misalign_err;
`ifdef WB_FORWARD_EN
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  writeback_stage dut (
    .clk           (clk),
    .rst           (rst),
    .flush         (flush),
    .in_valid      (in_valid),
    .in_reg_write  (in_reg_write),
    .in_rd         (in_rd),
    .in_result_src (in_result_src),
    .in_funct3     (in_funct3),
    .in_alu_result (in_alu_result),
    .in_mem_rdata  (in_mem_rdata),
    .in_pc_plus4   (in_pc_plus4),
    .write_en      (write_en),
    .write_addr    (write_addr),
    .write_data    (write_data),
    .retired       (retired),
    .misalign_err  (misalign_err)
`ifdef WB_FORWARD_EN
    ,
    .fwd_valid     (fwd_valid),
    .fwd_rd        (fwd_rd),
    .fwd_data      (fwd_data)
`endif
  );

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The instruction currently sitting in WB, as plain values.
  bit          m_ok = 0;
  bit          m_valid;
  bit          m_rw;
  int unsigned m_rd, m_src, m_f3;
  int unsigned m_alu, m_rdata, m_pc4;
  longint unsigned m_retired;
  bit          m_err;

  function automatic bit is_half(int unsigned f3);
    return (f3 == 1) || (f3 == 5);
  endfunction

  function automatic bit is_byte(int unsigned f3);
    return (f3 == 0) || (f3 == 4);
  endfunction

  function automatic bit exp_mis();
    int unsigned off;
    off = m_alu % 4;
    if (!m_valid || m_src != 1) return 0;
    if (is_half(m_f3)) return (off % 2) == 1;
    if (is_byte(m_f3)) return 0;
    return off != 0;
  endfunction

  function automatic int unsigned exp_data();
    int unsigned off, b, h;
    off = m_alu % 4;
    if (m_src == 2) return m_pc4;
    if (m_src != 1) return m_alu;
    b = (m_rdata >> (8 * off)) & 32'hFF;
    h = (m_rdata >> (16 * (off / 2))) & 32'hFFFF;
    case (m_f3)
      0:       return (b >= 128) ? b - 256 : b;
      4:       return b;
      1:       return (h >= 32768) ? h - 65536 : h;
      5:       return h;
      default: return m_rdata;
    endcase
  endfunction

  function automatic bit exp_we();
    return m_valid && m_rw && (m_rd != 0) && !exp_mis();
  endfunction

  // Advance the model on each clock edge using the inputs as sampled there.
  always @(posedge clk) begin
    if (rst) begin
      m_ok = 1; m_valid = 0; m_rw = 0; m_rd = 0; m_src = 0; m_f3 = 0;
      m_alu = 0; m_rdata = 0; m_pc4 = 0; m_retired = 0; m_err = 0;
    end else begin
      if (m_valid) m_retired = m_retired + 1;
      if (exp_mis()) m_err = 1;
      m_valid = in_valid && !flush;
      m_rw    = in_reg_write;
      m_rd    = in_rd;
      m_src   = in_result_src;
      m_f3    = in_funct3;
      m_alu   = in_alu_result;
      m_rdata = in_mem_rdata;
      m_pc4   = in_pc_plus4;
    end
  end

  // Compare the DUT against the model away from the active edge.
  always @(negedge clk) begin
    if (m_ok) begin
      chk("model write_en", write_en, exp_we());
      chk("model write_addr", write_addr, m_rd);
      chk("model write_data", write_data, exp_data());
      chk("model retired", retired, m_retired);
      chk("model misalign_err", misalign_err, m_err);
`ifdef WB_FORWARD_EN
      chk("fwd_valid", fwd_valid, write_en);
      chk("fwd_rd", fwd_rd, write_addr);
      chk("fwd_data", fwd_data, write_data);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic idle_inputs();
    flush = 0; in_valid = 0; in_reg_write = 0; in_rd = 0; in_result_src = 0;
    in_funct3 = 0; in_alu_result = 0; in_mem_rdata = 0; in_pc_plus4 = 0;
  endtask

  // Present one instruction for one edge, then land on the next negedge.
  task automatic apply(input bit v, input bit rw, input logic [4:0] rd,
                       input logic [1:0] src, input logic [2:0] f3,
                       input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc4, input bit fl);
    in_valid = v; in_reg_write = rw; in_rd = rd; in_result_src = src;
    in_funct3 = f3; in_alu_result = alu; in_mem_rdata = rdata;
    in_pc_plus4 = pc4; flush = fl;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1;
    idle_inputs();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset write_en", write_en, 0);
    chk("reset write_addr", write_addr, 0);
    chk("reset write_data", write_data, 0);
    chk("reset retired", retired, 0);
    chk("reset misalign_err", misalign_err, 0);
    rst = 0;

    // ALU writeback
    apply(1, 1, 5, 2'b00, 3'b000, 32'h1234, 32'h0, 32'h0, 0);
    chk("alu write_en", write_en, 1);
    chk("alu write_addr", write_addr, 5);
    chk("alu write_data", write_data, 32'h1234);

    // LB / LBU from byte 3
    apply(1, 1, 7, 2'b01, 3'b000, 32'h3, 32'h80FF_0011, 32'h0, 0);
    chk("lb write_data", write_data, 32'hFFFF_FF80);
    chk("lb write_en", write_en, 1);
    chk("retired after alu", retired, 1);
    apply(1, 1, 7, 2'b01, 3'b100, 32'h3, 32'h80FF_0011, 32'h0, 0);
    chk("lbu write_data", write_data, 32'h0000_0080);
    chk("retired after lb", retired, 2);

    // Misaligned LH: write suppressed, sticky flag, still retires
    apply(1, 1, 8, 2'b01, 3'b001, 32'h1, 32'h1234_5678, 32'h0, 0);
    chk("lh mis write_en", write_en, 0);
    idle(10);
    chk("lh mis sticky", misalign_err, 1);
    chk("retired after lh mis", retired, 4);

    // rd=0 never written; flush kills the instruction
    apply(1, 1, 0, 2'b00, 3'b000, 32'h55, 32'h0, 32'h0, 0);
    chk("rd0 write_en", write_en, 0);
    apply(1, 1, 9, 2'b00, 3'b000, 32'h99, 32'h0, 32'h0, 1);
    chk("flush write_en", write_en, 0);
    idle(1);
    chk("retired after flush", retired, 5);

    // JAL link value
    apply(1, 1, 1, 2'b10, 3'b000, 32'hDEAD, 32'h0, 32'h104, 0);
    chk("jal write_data", write_data, 32'h104);
    chk("jal write_en", write_en, 1);

    // Halfword upper lane, full word, misaligned word, reserved source
    apply(1, 1, 3, 2'b01, 3'b001, 32'h2, 32'h8001_7FFF, 32'h0, 0);
    chk("lh upper", write_data, 32'hFFFF_8001);
    apply(1, 1, 3, 2'b01, 3'b101, 32'h2, 32'h8001_7FFF, 32'h0, 0);
    chk("lhu upper", write_data, 32'h0000_8001);
    apply(1, 1, 3, 2'b01, 3'b010, 32'h100, 32'hCAFE_BABE, 32'h0, 0);
    chk("lw", write_data, 32'hCAFE_BABE);
    apply(1, 1, 3, 2'b01, 3'b010, 32'h102, 32'hCAFE_BABE, 32'h0, 0);
    chk("lw mis write_en", write_en, 0);
    apply(1, 1, 4, 2'b11, 3'b010, 32'h0BAD_F00D, 32'h1, 32'h2, 0);
    chk("rsvd src", write_data, 32'h0BAD_F00D);

    // Mixed vectors checked by the model
    for (int i = 0; i < 60; i++) begin
      apply($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            5'($urandom_range(0, 31)), 2'($urandom_range(0, 3)),
            3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
            $urandom_range(0, 7) == 0);
    end

    // Reset with an instruction in flight
    in_valid = 1; in_reg_write = 1; in_rd = 6; in_alu_result = 32'h77;
    rst = 1;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    chk("rst mid write_en", write_en, 0);
    chk("rst mid retired", retired, 0);
    chk("rst mid misalign_err", misalign_err, 0);
    rst = 0;
    idle(2);
    chk("post rst retired", retired, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
